// File: rtl/uart_pkg.sv
// Shared UART link constants: frame length, acknowledge pattern and receiver FSM states.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam logic [FRAME_BITS-1:0] ACK_BYTE_DEF = 8'hCC;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        ACK_GAP,
        ACK_START,
        ACK_DATA,
        ACK_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-clk pulse every round(CLK_FREQ / (BAUD * OVERSAMPLE)) clocks.
module uart_os_tick #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 19_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned TICK_RATE = BAUD * OVERSAMPLE;
    localparam int unsigned DIV       = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
    localparam int unsigned CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_rx_ack.sv
// 8N1 UART receiver that returns an acknowledge frame on ack_out after every frame with a good stop bit.
module uart_rx_ack
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 19_200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter logic [7:0]  ACK_BYTE     = ACK_BYTE_DEF,
    parameter int unsigned ACK_GAP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy,
    output logic       ack_out
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] BIT_FULL = 4'(FRAME_BITS);
    localparam logic [3:0] GAP_LAST = 4'(ACK_GAP_BITS - 1);

    logic            rst_meta, rst_n;
    logic            rx_meta, rx_sync;
    logic            tick, bit_end;
    rx_state_e       state_q, state_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      ack_sh_q, ack_sh_d;
    logic            armed_q, armed_d;
    logic            dv_d, fe_d, ack_d;

    // Reset asserts immediately, releases two clocks after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    uart_os_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_os_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign bit_end = tick && (os_cnt_q == OS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ack_sh_d  = ack_sh_q;
        armed_d   = armed_q | rx_sync;
        dv_d      = 1'b0;
        fe_d      = 1'b0;

        // Outside IDLE the sample counter free-runs over one bit period.
        if (tick && state_q != IDLE) os_cnt_d = bit_end ? '0 : os_cnt_q + OS_W'(1);

        case (state_q)
            IDLE: begin
                if (tick && rx_en && armed_q && !rx_sync) begin
                    state_d  = START;
                    os_cnt_d = '0;
                end
            end
            START: begin
                if (tick && os_cnt_q == OS_HALF_LAST) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    if (rx_sync) begin
                        fe_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {shift_q[6:0], rx_sync};
                    bit_cnt_d = (bit_cnt_q >= BIT_FULL) ? bit_cnt_q : bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (rx_sync) begin
                        dv_d    = 1'b1;
                        state_d = (ACK_GAP_BITS == 0) ? ACK_START : ACK_GAP;
                    end else begin
                        // Bad stop: wait for the line to return high before a new start.
                        fe_d    = 1'b1;
                        armed_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            ACK_GAP: begin
                if (bit_end) begin
                    if (bit_cnt_q == GAP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ACK_START;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK_START: begin
                if (bit_end) begin
                    ack_sh_d  = ACK_BYTE;
                    bit_cnt_d = '0;
                    state_d   = ACK_DATA;
                end
            end
            ACK_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ACK_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        ack_sh_d  = {ack_sh_q[6:0], 1'b1};
                    end
                end
            end
            ACK_STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            ACK_START: ack_d = 1'b0;
            ACK_DATA:  ack_d = ack_sh_d[7];
            default:   ack_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ack_sh_q   <= '0;
            armed_q    <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
            ack_out    <= 1'b1;
        end else begin
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_sh_q   <= ack_sh_d;
            armed_q    <= armed_d;
            data_valid <= dv_d;
            frame_err  <= fe_d;
            rx_busy    <= (state_d != IDLE);
            ack_out    <= ack_d;
            if (dv_d) data_out <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_ack.sv
// Directed bench for uart_rx_ack: good/bad frames, glitch, retransmit, reset mid-ack, rx_en gating.
module tb_uart_rx_ack;

    localparam int BIT_CLKS = 160;
    localparam logic [9:0] ACK_FRAME = 10'b0_11001100_1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, rx_busy, ack_out;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  dv_cnt = 0, fe_cnt = 0, both_cnt = 0, busy_cnt = 0, ack_low_cnt = 0;
    time dv_time = 0;
    time t_fall  = 0;

    uart_rx_ack #(
        .CLK_FREQ    (1_600_000),
        .BAUD        (10_000),
        .OVERSAMPLE  (16),
        .ACK_BYTE    (8'hCC),
        .ACK_GAP_BITS(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_en     (rx_en),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .ack_out   (ack_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            dv_time = $time;
        end
        if (frame_err) fe_cnt++;
        if (data_valid && frame_err) both_cnt++;
        if (rx_busy) busy_cnt++;
        if (!ack_out) ack_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx_in  = 1'b0;
        t_fall = $time;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            rx_in = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_in = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic wait_ack_low(output bit seen);
        int n = 0;
        while (ack_out !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        seen = (n < 3000);
        if (!seen) check("ack_start_seen", 32'(ack_out), 32'(0));
    endtask

    // Samples each ack bit at its centre, start bit first.
    task automatic capture_ack(output logic [9:0] bits, output int gap);
        bit seen;
        bits = '1;
        gap  = -1;
        wait_ack_low(seen);
        if (!seen) return;
        gap = int'(($time - dv_time) / 10);
        repeat (BIT_CLKS / 2) @(negedge clk);
        bits[9] = ack_out;
        for (int i = 8; i >= 0; i--) begin
            repeat (BIT_CLKS) @(negedge clk);
            bits[i] = ack_out;
        end
    endtask

    task automatic rx_and_ack(input logic [7:0] d);
        int         dv0;
        int         gap;
        longint     lat;
        logic [9:0] bits;
        dv0 = dv_cnt;
        send_frame(d, 1'b1);
        lat = longint'((dv_time - t_fall) / 10);
        check("dv_pulses", 32'(dv_cnt - dv0), 32'(1));
        check("data_out", 32'(data_out), 32'(d));
        check("dv_latency_in_window", 32'(lat >= 1522 && lat <= 1533), 32'(1));
        capture_ack(bits, gap);
        check("ack_gap_clks", 32'(gap), 32'(BIT_CLKS));
        check("ack_bits", 32'(bits), 32'(ACK_FRAME));
        repeat (120) @(negedge clk);
        check("idle_after_ack", 32'(rx_busy), 32'(0));
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dv0, fe0, busy0, ack0;
        bit  seen;

        // Reset values
        #3 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_data_valid", 32'(data_valid), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_rx_busy", 32'(rx_busy), 32'(0));
        check("rst_ack_out", 32'(ack_out), 32'(1));
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Good frame 0xA5
        rx_and_ack(8'hA5);

        // 0x3C with bad stop bit
        dv0 = dv_cnt; fe0 = fe_cnt; ack0 = ack_low_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (300) @(negedge clk);
        check("badstop_fe", 32'(fe_cnt - fe0), 32'(1));
        check("badstop_no_dv", 32'(dv_cnt - dv0), 32'(0));
        check("badstop_no_ack", 32'(ack_low_cnt - ack0), 32'(0));
        check("badstop_data_held", 32'(data_out), 32'(8'hA5));
        check("badstop_idle", 32'(rx_busy), 32'(0));

        // 40-clk low glitch -> false start
        dv0 = dv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
        rx_in = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'(1));
        check("glitch_no_dv", 32'(dv_cnt - dv0), 32'(0));
        check("glitch_idle", 32'(rx_busy), 32'(0));
        rx_and_ack(8'h00);

        // Original and retransmitted 0x11
        dv0 = dv_cnt;
        rx_and_ack(8'h11);
        rx_and_ack(8'h11);
        check("retx_two_dv", 32'(dv_cnt - dv0), 32'(2));

        // Reset in the middle of ack data bit 3
        send_frame(8'h5A, 1'b1);
        wait_ack_low(seen);
        repeat (700) @(negedge clk);
        check("ack_bit3_before_rst", 32'(ack_out), 32'(0));
        #2 reset = 1'b0;
        #1;
        check("midack_rst_ack_out", 32'(ack_out), 32'(1));
        check("midack_rst_rx_busy", 32'(rx_busy), 32'(0));
        check("midack_rst_data_out", 32'(data_out), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        rx_and_ack(8'hFF);

        // rx_en gating
        rx_en = 1'b0;
        dv0 = dv_cnt; busy0 = busy_cnt; ack0 = ack_low_cnt;
        send_frame(8'h55, 1'b1);
        repeat (300) @(negedge clk);
        check("rxen0_no_busy", 32'(busy_cnt - busy0), 32'(0));
        check("rxen0_no_dv", 32'(dv_cnt - dv0), 32'(0));
        check("rxen0_no_ack", 32'(ack_low_cnt - ack0), 32'(0));
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        rx_and_ack(8'h55);

        check("dv_fe_exclusive", 32'(both_cnt), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
